// File: rtl/conv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_pkg                                                                 |
// | Shared scheduler state type and image geometry for the stride-2 conv.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package conv_pkg;

  localparam int IMG_W_DEF      = 9;
  localparam int IMG_H_DEF      = 9;
  localparam int K_DEF          = 3;
  localparam int STRIDE_DEF     = 2;
  localparam int BANK1_BASE_DEF = 81;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    DRAIN   = 2'd2,
    RELEASE = 2'd3
  } sched_state_t;

  // Port/counter width for a value range of n, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/window_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | window_addr_gen                                                          |
// | Window/tap counters and read address built from running offsets.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module window_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int K      = K_DEF,
  parameter int STRIDE = STRIDE_DEF,
  parameter int ADDR_W = 10,
  localparam int OUT_W = (IMG_W - K) / STRIDE + 1,
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1,
  localparam int TAPS  = K * K,
  localparam int KC_W  = width_of(K),
  localparam int TAP_W = width_of(TAPS),
  localparam int ROW_W = width_of(OUT_H),
  localparam int COL_W = width_of(OUT_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_step,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_base,
  output logic [ADDR_W-1:0] o_addr,
  output logic [TAP_W-1:0]  o_tap,
  output logic [ROW_W-1:0]  o_orow,
  output logic [COL_W-1:0]  o_ocol,
  output logic              o_last_tap
);

  localparam logic [ADDR_W-1:0] C_KROW_STEP = ADDR_W'(IMG_W - (K - 1));
  localparam logic [ADDR_W-1:0] C_COL_STEP  = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] C_ROW_STEP  = ADDR_W'(STRIDE * IMG_W - STRIDE * (OUT_W - 1));

  logic [KC_W-1:0]   r_kc, r_kr;
  logic [TAP_W-1:0]  r_tap;
  logic [COL_W-1:0]  r_ocol;
  logic [ROW_W-1:0]  r_orow;
  logic [ADDR_W-1:0] r_win_off, r_tap_off;
  logic w_kc_end, w_kr_end, w_col_end, w_row_end;

  assign w_kc_end  = (r_kc == KC_W'(K - 1));
  assign w_kr_end  = (r_kr == KC_W'(K - 1));
  assign w_col_end = (r_ocol == COL_W'(OUT_W - 1));
  assign w_row_end = (r_orow == ROW_W'(OUT_H - 1));

  // r_win_off tracks the window's top-left pixel, r_tap_off the tap inside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kc <= '0; r_kr <= '0; r_tap <= '0; r_ocol <= '0; r_orow <= '0;
      r_win_off <= '0; r_tap_off <= '0;
    end else if (i_clear) begin
      r_kc <= '0; r_kr <= '0; r_tap <= '0; r_ocol <= '0; r_orow <= '0;
      r_win_off <= '0; r_tap_off <= '0;
    end else if (i_step) begin
      r_tap <= (w_kc_end && w_kr_end) ? '0 : r_tap + TAP_W'(1);
      if (!w_kc_end) begin
        r_kc      <= r_kc + KC_W'(1);
        r_tap_off <= r_tap_off + ADDR_W'(1);
      end else begin
        r_kc <= '0;
        if (!w_kr_end) begin
          r_kr      <= r_kr + KC_W'(1);
          r_tap_off <= r_tap_off + C_KROW_STEP;
        end else begin
          r_kr      <= '0;
          r_tap_off <= '0;
          if (!w_col_end) begin
            r_ocol    <= r_ocol + COL_W'(1);
            r_win_off <= r_win_off + C_COL_STEP;
          end else begin
            r_ocol <= '0;
            if (!w_row_end) begin
              r_orow    <= r_orow + ROW_W'(1);
              r_win_off <= r_win_off + C_ROW_STEP;
            end else begin
              r_orow    <= '0;
              r_win_off <= '0;
            end
          end
        end
      end
    end
  end

  assign o_addr     = i_base + r_win_off + r_tap_off;
  assign o_tap      = r_tap;
  assign o_orow     = r_orow;
  assign o_ocol     = r_ocol;
  assign o_last_tap = w_kc_end && w_kr_end && w_col_end && w_row_end;

endmodule
`default_nettype wire

// File: rtl/stride2_window_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stride2_window_sched                                                     |
// | Ping-pong bank read scheduler for the stride-2 conv; STRIDE2_SCHED_PERF_EN |
// | adds saturating stall/image counters.                                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module stride2_window_sched
  import conv_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int K          = K_DEF,
  parameter int STRIDE     = STRIDE_DEF,
  parameter int BANK1_BASE = BANK1_BASE_DEF,
  parameter int ADDR_W     = 10,
  parameter int RD_LAT     = 1,
  localparam int OUT_W   = (IMG_W - K) / STRIDE + 1,
  localparam int OUT_H   = (IMG_H - K) / STRIDE + 1,
  localparam int TAPS    = K * K,
  localparam int TAP_W   = width_of(TAPS),
  localparam int ROW_W   = width_of(OUT_H),
  localparam int COL_W   = width_of(OUT_W),
  localparam int DRAIN_W = width_of(RD_LAT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        bank_full,
  output logic [1:0]        bank_release,
  input  logic              out_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              tap_valid,
  output logic [TAP_W-1:0]  tap_idx,
  output logic              win_first,
  output logic              win_last,
  output logic [ROW_W-1:0]  win_row,
  output logic [COL_W-1:0]  win_col,
  output logic              busy,
  output logic              err
`ifdef STRIDE2_SCHED_PERF_EN
  ,
  output logic [15:0]       perf_stall,
  output logic [15:0]       perf_images
`endif
);

  sched_state_t      r_state, w_state_nxt;
  logic              r_next_bank;
  logic [DRAIN_W-1:0] r_drain;
  logic [1:0]        r_bank_release;
  logic              r_err, r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [TAP_W-1:0]  r_iss_idx;
  logic [ROW_W-1:0]  r_iss_row;
  logic [COL_W-1:0]  r_iss_col;
  logic              w_issue, w_clear, w_last_tap;
  logic [ADDR_W-1:0] w_base, w_addr;
  logic [TAP_W-1:0]  w_tap;
  logic [ROW_W-1:0]  w_orow;
  logic [COL_W-1:0]  w_ocol;

  logic              r_pv   [RD_LAT];
  logic [TAP_W-1:0]  r_pidx [RD_LAT];
  logic [ROW_W-1:0]  r_prow [RD_LAT];
  logic [COL_W-1:0]  r_pcol [RD_LAT];

  assign w_base = r_next_bank ? ADDR_W'(BANK1_BASE) : '0;

  window_addr_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .STRIDE(STRIDE), .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (reset),
    .i_step    (w_issue),
    .i_clear   (w_clear),
    .i_base    (w_base),
    .o_addr    (w_addr),
    .o_tap     (w_tap),
    .o_orow    (w_orow),
    .o_ocol    (w_ocol),
    .o_last_tap(w_last_tap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Only the expected bank is watched in IDLE, so images are served strictly alternately.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        w_clear = 1'b1;
        if (bank_full[r_next_bank]) w_state_nxt = SCAN;
      end
      SCAN: begin
        w_issue = out_ready;
        if (out_ready && w_last_tap) w_state_nxt = DRAIN;
      end
      DRAIN:   if (r_drain == DRAIN_W'(RD_LAT - 1)) w_state_nxt = RELEASE;
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_next_bank    <= 1'b0;
      r_drain        <= '0;
      r_bank_release <= 2'b00;
      r_err          <= 1'b0;
      r_rd_en        <= 1'b0;
      r_rd_addr      <= '0;
      r_iss_idx      <= '0;
      r_iss_row      <= '0;
      r_iss_col      <= '0;
    end else begin
      r_drain        <= (r_state == DRAIN) ? r_drain + DRAIN_W'(1) : '0;
      r_bank_release <= (r_state == RELEASE) ? (r_next_bank ? 2'b10 : 2'b01) : 2'b00;
      if (r_state == RELEASE) r_next_bank <= ~r_next_bank;
      if ((r_state == SCAN || r_state == DRAIN) && !bank_full[r_next_bank]) r_err <= 1'b1;
      r_rd_en   <= w_issue;
      if (w_issue) r_rd_addr <= w_addr;
      r_iss_idx <= w_issue ? w_tap  : '0;
      r_iss_row <= w_issue ? w_orow : '0;
      r_iss_col <= w_issue ? w_ocol : '0;
    end
  end

  // Tag pipeline never stalls: issued taps always emerge RD_LAT cycles later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pv[i] <= 1'b0; r_pidx[i] <= '0; r_prow[i] <= '0; r_pcol[i] <= '0;
      end
    end else begin
      r_pv[0] <= r_rd_en; r_pidx[0] <= r_iss_idx; r_prow[0] <= r_iss_row; r_pcol[0] <= r_iss_col;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1]; r_pidx[i] <= r_pidx[i-1];
        r_prow[i] <= r_prow[i-1]; r_pcol[i] <= r_pcol[i-1];
      end
    end
  end

  assign bank_release = r_bank_release;
  assign rd_en        = r_rd_en;
  assign rd_addr      = r_rd_addr;
  assign tap_valid    = r_pv[RD_LAT-1];
  assign tap_idx      = r_pidx[RD_LAT-1];
  assign win_row      = r_prow[RD_LAT-1];
  assign win_col      = r_pcol[RD_LAT-1];
  assign win_first    = tap_valid && (tap_idx == '0);
  assign win_last     = tap_valid && (tap_idx == TAP_W'(TAPS - 1));
  assign busy         = (r_state != IDLE);
  assign err          = r_err;

`ifdef STRIDE2_SCHED_PERF_EN
  logic [15:0] r_perf_stall, r_perf_images;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_stall  <= '0;
      r_perf_images <= '0;
    end else begin
      if (r_state == SCAN && !out_ready && r_perf_stall != 16'hFFFF)
        r_perf_stall <= r_perf_stall + 16'd1;
      if (r_state == RELEASE && r_perf_images != 16'hFFFF)
        r_perf_images <= r_perf_images + 16'd1;
    end
  end

  assign perf_stall  = r_perf_stall;
  assign perf_images = r_perf_images;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stride2_window_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_stride2_window_sched                                                  |
// | Directed bench with an arithmetic window-scan model checked every cycle. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_stride2_window_sched;

  localparam int IMG_W = 9, K = 3, STRIDE = 2, BANK1 = 81;
  localparam int OUT_W = 4, TAPS = 9, PER_IMG = 144, RD_LAT = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] bank_full = 2'b00;
  logic       out_ready = 1'b0;
  logic [1:0] bank_release;
  logic       rd_en, tap_valid, win_first, win_last, busy, err;
  logic [9:0] rd_addr;
  logic [3:0] tap_idx;
  logic [1:0] win_row, win_col;
`ifdef STRIDE2_SCHED_PERF_EN
  logic [15:0] perf_stall, perf_images;
`endif

  stride2_window_sched dut (
    .clk(clk), .reset(reset), .bank_full(bank_full), .bank_release(bank_release),
    .out_ready(out_ready), .rd_en(rd_en), .rd_addr(rd_addr), .tap_valid(tap_valid),
    .tap_idx(tap_idx), .win_first(win_first), .win_last(win_last),
    .win_row(win_row), .win_col(win_col), .busy(busy), .err(err)
`ifdef STRIDE2_SCHED_PERF_EN
    , .perf_stall(perf_stall), .perf_images(perf_images)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, stall_cnt = 0, last_rd_cyc = 0;
  int iss_cur = 0, tap_cur = 0, m_bank = 0;
  logic rdy_at_edge = 1'b0, prev_rd_en = 1'b0, exp_err = 1'b0;
  int cap_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Window-major raster scan: window n/TAPS, tap n%TAPS inside the KxK window.
  function automatic int model_addr(input int bank, input int n);
    int t, w;
    t = n % TAPS;
    w = n / TAPS;
    return bank * BANK1 + (STRIDE * (w / OUT_W) + t / K) * IMG_W + STRIDE * (w % OUT_W) + t % K;
  endfunction

  always @(posedge clk) begin
    cyc++;
    rdy_at_edge = out_ready;
    if (!reset) stall_cnt = 0;
    else if (busy && !out_ready) stall_cnt++;
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("reset_outputs", {rd_en, rd_addr, tap_valid, tap_idx, win_row, win_col,
                              win_first, win_last, busy, err, bank_release}, 0);
      iss_cur = 0; tap_cur = 0; m_bank = 0; prev_rd_en = 1'b0;
    end else begin
      if (rd_en) begin
        check("rd_en_after_ready", rdy_at_edge, 1);
        check("issue_in_range", iss_cur < PER_IMG, 1);
        if (iss_cur < PER_IMG) check("rd_addr", rd_addr, model_addr(m_bank, iss_cur));
        iss_cur++;
        last_rd_cyc = cyc;
        cap_q.push_back(int'(rd_addr));
      end
      check("tap_valid_delay", tap_valid, prev_rd_en);
      if (tap_valid) begin
        int t, w;
        logic [9:0] etag;
        t = tap_cur % TAPS;
        w = tap_cur / TAPS;
        etag = {4'(t), 2'(w / OUT_W), 2'(w % OUT_W), (t == 0), (t == TAPS - 1)};
        check("tap_tags", {tap_idx, win_row, win_col, win_first, win_last}, etag);
        tap_cur++;
      end else begin
        check("first_last_idle", {win_first, win_last}, 0);
      end
      prev_rd_en = rd_en;
      check("err", err, exp_err);
      if (rd_en || tap_valid) check("busy_active", busy, 1);
      if (bank_release != 2'b00) begin
        check("release_bank", bank_release, (m_bank == 0) ? 2'b01 : 2'b10);
        check("release_counts", {iss_cur[15:0], tap_cur[15:0]}, {16'(PER_IMG), 16'(PER_IMG)});
        check("release_delay", cyc - last_rd_cyc, RD_LAT + 1);
        m_bank ^= 1;
        iss_cur = 0;
        tap_cur = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    exp_err = 1'b0;
    cap_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_release(input int limit, output logic [1:0] rel);
    rel = 2'b00;
    for (int k = 0; k < limit && rel == 2'b00; k++) begin
      @(negedge clk);
      if (bank_release != 2'b00) begin
        rel = bank_release;
        bank_full = bank_full & ~bank_release;
      end
    end
    check("release_seen", rel != 2'b00, 1);
  endtask

  task automatic wait_taps(input int n, input int limit);
    for (int k = 0; k < limit && cap_q.size() < n; k++) @(negedge clk);
    check("tap_wait", cap_q.size() >= n, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [1:0] rel, rel2;
    int exp1[10];
    int pat[8];
    int t1_q[$];
    int diffs;
    exp1 = '{0, 1, 2, 9, 10, 11, 18, 19, 20, 2};
    pat  = '{1, 0, 0, 1, 1, 0, 1, 0};

    // Test 1: bank 0, always ready
    do_reset();
    out_ready = 1'b1;
    bank_full = 2'b01;
    wait_release(400, rel);
    check("t1_release", rel, 2'b01);
    check("t1_count", cap_q.size(), PER_IMG);
    for (int i = 0; i < 10; i++) check("t1_first_addrs", cap_q[i], exp1[i]);
    check("t1_last_addr", cap_q[PER_IMG-1], 80);
    t1_q = cap_q;

    // Test 2: next image in bank 1
    cap_q.delete();
    @(posedge clk);
    #1 bank_full = 2'b10;
    wait_release(400, rel);
    check("t2_release", rel, 2'b10);
    check("t2_count", cap_q.size(), PER_IMG);
    check("t2_first_addr", cap_q[0], 81);
    check("t2_last_addr", cap_q[PER_IMG-1], 161);

    // Test 3: both banks full from reset
    bank_full = 2'b11;
    do_reset();
    wait_release(400, rel);
    wait_release(400, rel2);
    check("t3_release_order", {rel, rel2}, 4'b0110);
    check("t3_count", cap_q.size(), 2 * PER_IMG);
    check("t3_bank1_start", cap_q[PER_IMG], 81);

    // Test 4: back-pressure on out_ready
    bank_full = 2'b00;
    do_reset();
    bank_full = 2'b01;
    rel = 2'b00;
    for (int k = 0; k < 2000 && rel == 2'b00; k++) begin
      @(posedge clk);
      #1;
      if (cap_q.size() < 140)
        out_ready = (k < 40) ? (pat[k % 8] != 0) : ($urandom_range(0, 1) != 0);
      else
        out_ready = 1'b1;
      @(negedge clk);
      if (bank_release != 2'b00) begin
        rel = bank_release;
        bank_full = bank_full & ~bank_release;
      end
    end
    check("t4_release", rel, 2'b01);
    check("t4_count", cap_q.size(), PER_IMG);
    diffs = 0;
    for (int i = 0; i < PER_IMG; i++)
      if (i >= cap_q.size() || cap_q[i] != t1_q[i]) diffs++;
    check("t4_stream_diffs", diffs, 0);
    check("t4_stalls_seen", stall_cnt > 0, 1);
`ifdef STRIDE2_SCHED_PERF_EN
    check("t4_perf_stall", perf_stall, stall_cnt);
    check("t4_perf_images", perf_images, 1);
`endif
    out_ready = 1'b1;

    // Test 5: reset in the middle of a scan
    do_reset();
    bank_full = 2'b01;
    wait_taps(50, 400);
    #2 reset = 1'b0;
    exp_err = 1'b0;
    #1 check("t5_async_clear", {rd_en, rd_addr, busy, tap_valid, bank_release}, 0);
    cap_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    wait_release(400, rel);
    check("t5_release", rel, 2'b01);
    check("t5_restart_addr", cap_q[0], 0);
    check("t5_count", cap_q.size(), PER_IMG);

    // Test 6: writer drops bank_full mid-scan
    bank_full = 2'b00;
    do_reset();
    bank_full = 2'b01;
    wait_taps(30, 400);
    @(posedge clk);
    #1 bank_full = 2'b00;
    @(posedge clk);
    #1 exp_err = 1'b1;
    wait_release(400, rel);
    check("t6_release", rel, 2'b01);
    check("t6_count", cap_q.size(), PER_IMG);
    repeat (3) @(negedge clk);
    check("t6_err_sticky", err, 1);
`ifdef STRIDE2_SCHED_PERF_EN
    check("t6_perf_images", perf_images, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
